// File: rtl/scalable_mix_pkg.sv
// Shared mode encodings, default sizes and the width-generic rotate helper
// for the scalable mixing pipe.
package scalable_mix_pkg;

  localparam logic MIX_OR  = 1'b0;
  localparam logic MIX_XOR = 1'b1;

  localparam int unsigned DEF_N = 6;
  localparam int unsigned DEF_W = 7;
  localparam int unsigned DEF_S = 3;

  // Widest channel the rotate helper supports; narrower values are zero-extended.
  localparam int unsigned MAX_W = 64;
  localparam int unsigned IDX_W = $clog2(MAX_W);

  // Rotate the low w bits of x left by one; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] x, input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    r[0] = x[IDX_W'(w - 1)];
    for (int unsigned i = 1; i < MAX_W; i++) begin
      if (i < w) r[IDX_W'(i)] = x[IDX_W'(i - 1)];
    end
    return r;
  endfunction

endpackage

// File: rtl/scalable_mix_stage.sv
// One registered mixing stage: applies the OR/XOR neighbour mix on load and
// participates in the valid/ready chain.
module scalable_mix_stage
  import scalable_mix_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  input  logic [N*W-1:0] i_data,
  input  logic           i_mode,
  input  logic           i_dn_ready,
  output logic           o_ready_c,
  output logic           o_valid,
  output logic [N*W-1:0] o_data,
  output logic           o_mode
);

  localparam int unsigned NW = N * W;

  logic          r_valid;
  logic [NW-1:0] r_data;
  logic          r_mode;
  logic [NW-1:0] w_mix;

  // Each channel combines with its rotated upper neighbour, wrapping at N-1.
  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [W-1:0] w_self;
    logic [W-1:0] w_rot;
    assign w_self = i_data[c*W +: W];
    assign w_rot  = W'(rotl1(MAX_W'(i_data[((c + 1) % N)*W +: W]), W));
    assign w_mix[c*W +: W] = (i_mode == MIX_XOR) ? (w_self ^ w_rot) : (w_self | w_rot);
  end

  assign o_ready_c = !r_valid || i_dn_ready;

  // An invalid source clears valid but leaves the data register untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MIX_OR;
    end else if (o_ready_c) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_mix;
        r_mode <= i_mode;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;

endmodule

// File: rtl/scalable_mix_pipe.sv
// N-channel, W-bit, S-stage mixing pipe with valid/ready flow control.
// Define SCALABLE_MIX_PIPE_COUNT_EN to add the 16-bit downstream transfer counter.
module scalable_mix_pipe
  import scalable_mix_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W,
  parameter int unsigned S = DEF_S
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic           in_mode,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_mode,
  output logic           out_valid,
  input  logic           out_ready
`ifdef SCALABLE_MIX_PIPE_COUNT_EN
  ,
  output logic [15:0]    xfer_count
`endif
);

  localparam int unsigned NW = N * W;

  logic [NW-1:0] w_data [S+1];
  logic [S:0]    w_valid;
  logic [S:0]    w_mode;
  logic [S:0]    w_ready;

  assign w_data[0]  = in_data;
  assign w_valid[0] = in_valid;
  assign w_mode[0]  = in_mode;
  assign w_ready[S] = out_ready;
  assign in_ready   = w_ready[0];

  for (genvar k = 0; k < S; k++) begin : g_stage
    scalable_mix_stage #(.N(N), .W(W)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (w_valid[k]),
      .i_data     (w_data[k]),
      .i_mode     (w_mode[k]),
      .i_dn_ready (w_ready[k+1]),
      .o_ready_c  (w_ready[k]),
      .o_valid    (w_valid[k+1]),
      .o_data     (w_data[k+1]),
      .o_mode     (w_mode[k+1])
    );
  end

  assign out_data  = w_data[S];
  assign out_valid = w_valid[S];
  assign out_mode  = w_mode[S];

`ifdef SCALABLE_MIX_PIPE_COUNT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] r_xfer_count;

  // Free-running wrap at 0xFFFF is intended.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      r_xfer_count <= r_xfer_count + CNT_W'(1);
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_scalable_mix_pipe.sv
// Scoreboard bench for scalable_mix_pipe: random and directed traffic checked
// against an arithmetic per-channel model of the S-stage mix.
module tb_scalable_mix_pipe;

  localparam int N  = 6;
  localparam int W  = 7;
  localparam int S  = 3;
  localparam int NW = N * W;

  typedef struct {
    logic [NW-1:0] data;
    logic          mode;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NW-1:0] in_data;
  logic          in_mode;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] out_data;
  logic          out_mode;
  logic          out_valid;
  logic          out_ready;
`ifdef SCALABLE_MIX_PIPE_COUNT_EN
  logic [15:0]   xfer_count;
`endif

  int checks   = 0;
  int failures = 0;
  int n_xfer   = 0;
  exp_t exp_q[$];

  scalable_mix_pipe #(.N(N), .W(W), .S(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SCALABLE_MIX_PIPE_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: S rounds of ch[i] = ch[i] op rotl(ch[i+1 mod N]) on integers.
  function automatic logic [NW-1:0] model(input logic [NW-1:0] d, input logic m);
    int ch [N];
    int nx [N];
    int rot;
    logic [NW-1:0] r;
    for (int i = 0; i < N; i++) ch[i] = int'(d[i*W +: W]);
    for (int s = 0; s < S; s++) begin
      for (int i = 0; i < N; i++) begin
        rot = ((ch[(i + 1) % N] * 2) % (1 << W)) + (ch[(i + 1) % N] / (1 << (W - 1)));
        nx[i] = m ? (ch[i] ^ rot) : (ch[i] | rot);
      end
      ch = nx;
    end
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(ch[i]);
    return r;
  endfunction

  function automatic logic [NW-1:0] fill(input int v);
    logic [NW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [NW-1:0] rnd_word();
    return NW'({$urandom(), $urandom()});
  endfunction

  // Monitor: samples at negedge, where the handshake for the next posedge is settled.
  logic          prev_hold = 1'b0;
  logic [NW-1:0] prev_od;
  logic          prev_om;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      n_xfer = 0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!(out_valid && out_data == prev_od && out_mode == prev_om)) begin
          failures++;
          $display("FAIL stall_hold: valid=%0b data=%h mode=%0b, required valid=1 data=%h mode=%0b",
                   out_valid, out_data, out_mode, prev_od, prev_om);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        n_xfer++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: data=%h with empty scoreboard", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_mode !== e.mode) begin
            failures++;
            $display("FAIL out_word: data=%h mode=%0b, required data=%h mode=%0b",
                     out_data, out_mode, e.data, e.mode);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.data = model(in_data, in_mode);
        e.mode = in_mode;
        exp_q.push_back(e);
      end
    end
    prev_hold = rst_n && out_valid && !out_ready;
    prev_od   = out_data;
    prev_om   = out_mode;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Hold a word until accepted; optionally jitter out_ready while waiting.
  task automatic send(input logic [NW-1:0] d, input logic m, input bit jitter);
    int t;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      tick();
      if (jitter) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=0, required 1 within 200 cycles");
    end
    tick();
    in_valid = 1'b0;
    if (jitter) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    logic [NW-1:0] words [5];
    int acc;
    int k;
    bit rdy_now;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = fill(7'h55);
    in_mode   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("reset_out_valid", NW'(out_valid), '0);
    check("reset_out_data", out_data, '0);
    check("reset_out_mode", NW'(out_mode), '0);
    check("reset_in_ready", NW'(in_ready), NW'(1));

    // Directed patterns; latency measured on an empty pipe.
    send(fill(7'h7f), 1'b0, 1'b0);
    k = 1;
    while (!out_valid && k < 50) begin tick(); k++; end
    check("latency", NW'(k), NW'(S));
    check("or_all_ones", out_data, fill(7'h7f));
    check("or_mode", NW'(out_mode), '0);
    drain();
    send(fill(7'h7f), 1'b1, 1'b0);
    drain();
    words[0] = '0;
    words[0][3*W +: W] = 7'h3f;
    send(words[0], 1'b1, 1'b0);
    drain();

    // Backpressure: only S words fit while the output is stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) words[i] = rnd_word();
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = words[acc];
      in_mode = acc[0];
      rdy_now = in_ready;
      tick();
      if (rdy_now) acc++;
    end
    check("bp_accepts", NW'(acc), NW'(S));
    check("bp_in_ready_low", NW'(in_ready), '0);
    out_ready = 1'b1;
    while (acc < 5) begin
      in_data = words[acc];
      in_mode = acc[0];
      rdy_now = in_ready;
      tick();
      if (rdy_now) acc++;
    end
    in_valid = 1'b0;
    drain();

    // Reset with two words in flight, then one word must appear after exactly S cycles.
    out_ready = 1'b0;
    send(rnd_word(), 1'b0, 1'b0);
    send(rnd_word(), 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("midrst_out_valid", NW'(out_valid), '0);
    repeat (4) tick();
    check("midrst_no_word", NW'(out_valid), '0);
    send(rnd_word(), 1'b1, 1'b0);
    k = 1;
    while (!out_valid && k < 50) begin tick(); k++; end
    check("midrst_latency", NW'(k), NW'(S));
    drain();

    // Randomised traffic with bubbles and jittering downstream ready.
    for (int i = 0; i < 300; i++) begin
      send(rnd_word(), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    drain();

    // Full-rate streaming: back-to-back accepts with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      in_data = rnd_word();
      in_mode = 1'($urandom_range(0, 1));
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("throughput", NW'(acc), NW'(50));
    drain();

`ifdef SCALABLE_MIX_PIPE_COUNT_EN
    check("count_matches", NW'(xfer_count), NW'(16'(n_xfer)));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    k = 0;
    while (n_xfer < 65537 && k < 70000) begin
      in_data = rnd_word();
      in_mode = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("count_wrap", NW'(xfer_count), NW'(1));
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
